// File: rtl/encoder_rpm_meter_pkg.sv
// enc_pkg: shared step encoding, saturation limits, window FSM states and Gray-index helper
package enc_pkg;
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_ERR  = 2'd2,
    STEP_REV  = 2'd3
  } step_e;
  localparam logic [10:0] RPM_MAX = 11'd2047;
  localparam logic signed [15:0] EDGE_MAX = 16'sd32767;
  typedef enum logic [1:0] {RUN, MUL, UPDATE} win_state_e;
  // Position of an AB code in the 00-01-11-10 cycle; index difference mod 4 is the step code.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction
endpackage

// File: rtl/encoder_rpm_meter_if.sv
// encoder_rpm_meter_if: encoder pins in (enc_in), measurement conduit out (rpm, rpm_valid, dir, position, quad_err, err_count)
interface encoder_rpm_meter_if;
  logic [1:0]  enc_in;
  logic [10:0] rpm;
  logic        rpm_valid;
  logic        dir;
  logic [31:0] position;
  logic        quad_err;
  logic [7:0]  err_count;
  modport master (output enc_in, input rpm, rpm_valid, dir, position, quad_err, err_count);
  modport slave (input enc_in, output rpm, rpm_valid, dir, position, quad_err, err_count);
endinterface

// File: rtl/encoder_rpm_meter_quad_decoder.sv
// quad_decoder: 2-FF sync + per-bit stable filter + x4 step decode; in clk_clk, reset_reset, enc_in; out step_fwd/step_rev/step_err pulses
module quad_decoder
  import enc_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [1:0] enc_in,
  output logic       step_fwd,
  output logic       step_rev,
  output logic       step_err
);
  localparam logic [3:0] FL_N = 4'(FILTER_LEN);
  localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
  logic [1:0] s1_q, s1_d, s2_q, s2_d, filt_q, filt_d, prev_q, prev_d, fill_q, fill_d;
  logic [3:0] ld_cnt_q, ld_cnt_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic loaded_q, loaded_d;
  step_e step;
  always_comb begin
    s1_d = enc_in;
    s2_d = s1_q;
    fill_d = fill_q == 2'd2 ? fill_q : fill_q + 2'd1;
    ld_cnt_d = ld_cnt_q;
    loaded_d = loaded_q;
    filt_d = filt_q;
    cnt_d = cnt_q;
    // Until loaded, filt_q tracks the latest real synced sample and becomes the start state once stable.
    if (!loaded_q) begin
      if (fill_q == 2'd2) begin
        ld_cnt_d = s2_q == filt_q ? ld_cnt_q + 4'd1 : 4'd1;
        filt_d = s2_q;
        loaded_d = ld_cnt_d == FL_N;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_d[i] = (s2_q[i] == filt_q[i] || cnt_q[i] == FL_LAST) ? 4'd0 : cnt_q[i] + 4'd1;
        if (s2_q[i] != filt_q[i] && cnt_q[i] == FL_LAST) filt_d[i] = s2_q[i];
      end
    end
    // The initial load copies into prev as well so it never decodes as a step.
    prev_d = loaded_q ? filt_q : filt_d;
    step = step_e'(gray_idx(filt_q) - gray_idx(prev_q));
    step_fwd = step == STEP_FWD;
    step_rev = step == STEP_REV;
    step_err = step == STEP_ERR;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_q <= '0;
      s2_q <= '0;
      filt_q <= '0;
      prev_q <= '0;
      fill_q <= '0;
      ld_cnt_q <= '0;
      cnt_q <= '{default: '0};
      loaded_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      fill_q <= fill_d;
      ld_cnt_q <= ld_cnt_d;
      cnt_q <= cnt_d;
      loaded_q <= loaded_d;
    end
  end
endmodule

// File: rtl/encoder_rpm_meter.sv
// encoder_rpm_meter: quadrature position counter and gated RPM meter; in clk_clk, reset_reset, bus.enc_in; out bus.rpm/rpm_valid/dir/position/quad_err/err_count
module encoder_rpm_meter
  import enc_pkg::*;
#(
  parameter int GATE_CYCLES = 5000000,
  parameter int FILTER_LEN = 4,
  parameter logic [15:0] RPM_MUL = 16'd32768,
  parameter int RPM_SHIFT = 16
) (
  input logic clk_clk,
  input logic reset_reset,
  encoder_rpm_meter_if.slave bus
);
  localparam int WW = $clog2(GATE_CYCLES);
  localparam logic [WW-1:0] WIN_LAST = WW'(GATE_CYCLES - 1);
  win_state_e state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic signed [15:0] acc_q, acc_d, snap_q, snap_d, acc_sat;
  logic signed [16:0] sum;
  logic [15:0] mag;
  logic [31:0] prod_q, prod_d, pos_q, pos_d, scaled;
  logic [10:0] rpm_q, rpm_d;
  logic [7:0] err_q, err_d;
  logic vld_q, vld_d, dir_q, dir_d, qerr_q, qerr_d, term, step_fwd, step_rev, step_err;
  quad_decoder #(.FILTER_LEN(FILTER_LEN)) u_dec (
    .clk_clk,
    .reset_reset,
    .enc_in(bus.enc_in),
    .step_fwd,
    .step_rev,
    .step_err
  );
  always_comb begin
    sum = {acc_q[15], acc_q} + (step_fwd ? 17'sd1 : step_rev ? -17'sd1 : 17'sd0);
    acc_sat = sum > 17'sd32767 ? EDGE_MAX : sum < -17'sd32767 ? -EDGE_MAX : sum[15:0];
    term = win_q == WIN_LAST;
    win_d = term ? '0 : win_q + WW'(1);
    // The terminal cycle's step lands in the snapshot; the new window starts empty.
    acc_d = term ? '0 : acc_sat;
    snap_d = term ? acc_sat : snap_q;
    state_d = term ? MUL : state_q == MUL ? UPDATE : RUN;
    mag = snap_q[15] ? 16'(-snap_q) : snap_q;
    prod_d = state_q == MUL ? 32'(mag) * 32'(RPM_MUL) : prod_q;
    scaled = prod_q >> RPM_SHIFT;
    rpm_d = state_q == UPDATE ? (scaled > 32'(RPM_MAX) ? RPM_MAX : scaled[10:0]) : rpm_q;
    vld_d = state_q == UPDATE;
    dir_d = state_q == UPDATE && snap_q != '0 ? !snap_q[15] : dir_q;
    pos_d = pos_q + (step_fwd ? 32'd1 : step_rev ? '1 : '0);
    qerr_d = step_err;
    err_d = err_q + 8'(step_err && err_q != 8'hff);
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= RUN;
      win_q <= '0;
      acc_q <= '0;
      snap_q <= '0;
      prod_q <= '0;
      rpm_q <= '0;
      vld_q <= 1'b0;
      dir_q <= 1'b0;
      pos_q <= '0;
      qerr_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      acc_q <= acc_d;
      snap_q <= snap_d;
      prod_q <= prod_d;
      rpm_q <= rpm_d;
      vld_q <= vld_d;
      dir_q <= dir_d;
      pos_q <= pos_d;
      qerr_q <= qerr_d;
      err_q <= err_d;
    end
  end
  assign bus.rpm = rpm_q;
  assign bus.rpm_valid = vld_q;
  assign bus.dir = dir_q;
  assign bus.position = pos_q;
  assign bus.quad_err = qerr_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_encoder_rpm_meter.sv
// tb_encoder_rpm_meter: randomized scenarios against a window/latency arithmetic model of the meter
module tb_encoder_rpm_meter;
  localparam int G = 1000;
  localparam int NW = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  encoder_rpm_meter_if b0 ();
  encoder_rpm_meter_if b1 ();
  logic [1:0] enc [2];
  assign b0.enc_in = enc[0];
  assign b1.enc_in = enc[1];
  encoder_rpm_meter #(.GATE_CYCLES(G), .FILTER_LEN(4)) dut0 (.clk_clk(clk), .reset_reset(rst), .bus(b0));
  encoder_rpm_meter #(.GATE_CYCLES(G), .FILTER_LEN(1)) dut1 (.clk_clk(clk), .reset_reset(rst), .bus(b1));
  logic vld [2];
  logic dir [2];
  logic qerr [2];
  logic [10:0] rpm [2];
  logic [31:0] pos [2];
  logic [7:0] errc [2];
  always_comb begin
    vld[0] = b0.rpm_valid; vld[1] = b1.rpm_valid;
    dir[0] = b0.dir; dir[1] = b1.dir;
    qerr[0] = b0.quad_err; qerr[1] = b1.quad_err;
    rpm[0] = b0.rpm; rpm[1] = b1.rpm;
    pos[0] = b0.position; pos[1] = b1.position;
    errc[0] = b0.err_count; errc[1] = b1.err_count;
  end
  int cyc;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  int errors = 0;
  int checks = 0;
  int fl [2] = '{4, 1};
  int exp_net [2][NW];
  int exp_pos [2];
  int exp_err [2];
  bit exp_dir [2];
  int qerr_seen [2];
  int valid_seen [2];
  logic [1:0] mprev [2];
  logic [1:0] cyc_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int seq_pos(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (cyc_seq[i] == v) return i;
    return 0;
  endfunction

  // Advance one cycle; every rpm_valid is checked against the expected net edges of its window.
  task automatic tick();
    int w, n, e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (qerr[d]) qerr_seen[d]++;
      if (vld[d]) begin
        checks++;
        if (rst || cyc < G + 2 || (cyc - 2) % G != 0 || (cyc - 2) / G - 1 >= NW) begin
          errors++;
          $display("FAIL rpm_valid_timing dut%0d: pulse at cycle %0d, allowed only at k*%0d+2", d, cyc, G);
        end else begin
          w = (cyc - 2) / G - 1;
          n = exp_net[d][w];
          n = n > 32767 ? 32767 : n < -32767 ? -32767 : n;
          e = ((n < 0 ? -n : n) * 32768) >>> 16;
          e = e > 2047 ? 2047 : e;
          if (n > 0) exp_dir[d] = 1'b1;
          else if (n < 0) exp_dir[d] = 1'b0;
          valid_seen[d]++;
          checks += 2;
          if (rpm[d] !== 11'(e)) begin
            errors++;
            $display("FAIL rpm_window dut%0d w%0d: got %0d expected %0d", d, w, rpm[d], e);
          end
          if (dir[d] !== exp_dir[d]) begin
            errors++;
            $display("FAIL dir_window dut%0d w%0d: got %0d expected %0d", d, w, dir[d], exp_dir[d]);
          end
        end
      end
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // Drive a new AB level and book its step into the window containing its decode cycle.
  task automatic apply(input int d, input logic [1:0] v);
    int a, diff, w;
    tick();
    a = cyc + 1;
    diff = (seq_pos(v) - seq_pos(mprev[d]) + 4) % 4;
    w = (a + 1 + fl[d]) / G;
    if (diff == 1) begin
      if (w < NW) exp_net[d][w]++;
      exp_pos[d]++;
    end else if (diff == 3) begin
      if (w < NW) exp_net[d][w]--;
      exp_pos[d]--;
    end else if (diff == 2) exp_err[d]++;
    mprev[d] = v;
    enc[d] = v;
  endtask

  task automatic do_reset(input logic [1:0] e0, input logic [1:0] e1, input int n);
    rst = 1'b1;
    enc[0] = e0;
    enc[1] = e1;
    hold(n);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_pos[d] = 0;
      exp_err[d] = 0;
      exp_dir[d] = 1'b0;
      qerr_seen[d] = 0;
      valid_seen[d] = 0;
      mprev[d] = enc[d];
      for (int w = 0; w < NW; w++) exp_net[d][w] = 0;
    end
  endtask

  task automatic test_reset();
    do_reset(2'b11, 2'b00, 5);
    checks++;
    if ({rpm[0], vld[0], dir[0], pos[0], qerr[0], errc[0]} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rpm=%0d vld=%0d dir=%0d pos=%0d qerr=%0d err=%0d, all required 0",
               rpm[0], vld[0], dir[0], pos[0], qerr[0], errc[0]);
    end
    while (cyc < G + 3) tick();
    checks += 3;
    if (valid_seen[0] !== 1 || valid_seen[1] !== 1) begin
      errors++;
      $display("FAIL first_valid: got %0d/%0d pulses, expected 1/1", valid_seen[0], valid_seen[1]);
    end
    if (pos[0] !== 32'd0) begin
      errors++;
      $display("FAIL load_no_edge: position %0d expected 0", $signed(pos[0]));
    end
    if (qerr_seen[0] !== 0 || errc[0] !== 8'd0) begin
      errors++;
      $display("FAIL load_no_err: quad_err pulses %0d err_count %0d expected 0", qerr_seen[0], errc[0]);
    end
  endtask

  task automatic test_quadrature(input bit fwd);
    int i = 0;
    do_reset(2'b00, 2'b00, 3);
    hold(8);
    while (cyc < 3 * G + 20) begin
      i = fwd ? i + 1 : i + 3;
      apply(0, cyc_seq[i % 4]);
      hold(9);
    end
    checks += 3;
    if (pos[0] !== 32'(exp_pos[0]) || (fwd ? exp_pos[0] <= 0 : exp_pos[0] >= 0)) begin
      errors++;
      $display("FAIL quad_position fwd=%0d: got %0d expected %0d", fwd, $signed(pos[0]), exp_pos[0]);
    end
    if (rpm[0] !== 11'd50 || dir[0] !== fwd) begin
      errors++;
      $display("FAIL quad_rpm fwd=%0d: rpm %0d dir %0d expected 50/%0d", fwd, rpm[0], dir[0], fwd);
    end
    if (valid_seen[0] !== (cyc - 2) / G) begin
      errors++;
      $display("FAIL quad_valid_count: got %0d expected %0d", valid_seen[0], (cyc - 2) / G);
    end
  endtask

  task automatic test_error();
    do_reset(2'b00, 2'b00, 3);
    hold(8);
    apply(0, 2'b11);
    hold(10);
    checks++;
    if (qerr_seen[0] !== 1 || errc[0] !== 8'd1 || pos[0] !== 32'd0) begin
      errors++;
      $display("FAIL single_err: pulses %0d err_count %0d pos %0d expected 1/1/0", qerr_seen[0], errc[0], $signed(pos[0]));
    end
    for (int k = 0; k < 255; k++) begin
      apply(0, mprev[0] ^ 2'b11);
      hold(4);
    end
    hold(10);
    checks++;
    if (qerr_seen[0] !== exp_err[0] || errc[0] !== 8'(exp_err[0] > 255 ? 255 : exp_err[0]) || pos[0] !== 32'd0) begin
      errors++;
      $display("FAIL err_saturate: pulses %0d err_count %0d pos %0d expected %0d/255/0", qerr_seen[0], errc[0], $signed(pos[0]), exp_err[0]);
    end
  endtask

  task automatic test_glitch();
    do_reset(2'b00, 2'b00, 3);
    hold(8);
    for (int k = 0; k < 20; k++) begin
      enc[0] = 2'b10;
      hold(3);
      enc[0] = 2'b00;
      hold(3 + $urandom_range(0, 5));
    end
    while (cyc < G + 5) tick();
    checks++;
    if (pos[0] !== 32'd0 || qerr_seen[0] !== 0 || rpm[0] !== 11'd0 || valid_seen[0] !== 1) begin
      errors++;
      $display("FAIL glitch_reject: pos %0d qerr %0d rpm %0d valids %0d expected 0/0/0/1", $signed(pos[0]), qerr_seen[0], rpm[0], valid_seen[0]);
    end
  endtask

  task automatic test_random();
    int r, p;
    do_reset(2'b00, 2'b00, 3);
    hold(8);
    while (cyc < 4 * G + 20) begin
      r = $urandom_range(0, 19);
      p = seq_pos(mprev[0]);
      if (r == 0) apply(0, mprev[0] ^ 2'b11);
      else if ((r < 16) == ((cyc / G) % 2 == 0)) apply(0, cyc_seq[(p + 1) % 4]);
      else apply(0, cyc_seq[(p + 3) % 4]);
      hold($urandom_range(3, 15));
    end
    hold(10);
    checks += 2;
    if (pos[0] !== 32'(exp_pos[0]) || errc[0] !== 8'(exp_err[0] > 255 ? 255 : exp_err[0])) begin
      errors++;
      $display("FAIL random_state: pos %0d err %0d expected %0d/%0d", $signed(pos[0]), errc[0], exp_pos[0], exp_err[0]);
    end
    if (valid_seen[0] !== (cyc - 2) / G || qerr_seen[0] !== exp_err[0]) begin
      errors++;
      $display("FAIL random_counts: valids %0d qerr %0d expected %0d/%0d", valid_seen[0], qerr_seen[0], (cyc - 2) / G, exp_err[0]);
    end
  endtask

  task automatic test_fast();
    int i = 0;
    do_reset(2'b00, 2'b00, 3);
    hold(8);
    while (cyc < 3 * G + 5) begin
      i++;
      apply(1, cyc_seq[i % 4]);
    end
    hold(5);
    checks += 2;
    if (rpm[1] !== 11'd500 || dir[1] !== 1'b1) begin
      errors++;
      $display("FAIL fast_rpm: rpm %0d dir %0d expected 500/1", rpm[1], dir[1]);
    end
    if (pos[1] !== 32'(exp_pos[1])) begin
      errors++;
      $display("FAIL fast_position: got %0d expected %0d", $signed(pos[1]), exp_pos[1]);
    end
  endtask

  task automatic test_terminal();
    int s;
    do_reset(2'b00, 2'b00, 3);
    hold(8);
    for (int k = 1; k <= 4; k++) begin
      s = G - 1 - 4 * (4 - k);
      while (cyc < s - 7) tick();
      apply(0, cyc_seq[k % 4]);
    end
    while (cyc < G + 5) tick();
    checks++;
    if (rpm[0] !== 11'd2 || dir[0] !== 1'b1) begin
      errors++;
      $display("FAIL terminal_edge: rpm %0d dir %0d expected 2/1", rpm[0], dir[0]);
    end
    while (cyc < 2 * G + 5) tick();
    checks++;
    if (rpm[0] !== 11'd0 || dir[0] !== 1'b1 || valid_seen[0] !== 2) begin
      errors++;
      $display("FAIL zero_window: rpm %0d dir %0d valids %0d expected 0/1/2", rpm[0], dir[0], valid_seen[0]);
    end
    for (int k = 0; k < 20; k++) begin
      apply(0, cyc_seq[(seq_pos(mprev[0]) + 1) % 4]);
      hold(4);
    end
    while (cyc % G != 500) tick();
    do_reset(enc[0], enc[1], 3);
    checks++;
    if (pos[0] !== 32'd0 || rpm[0] !== 11'd0 || dir[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: pos %0d rpm %0d dir %0d expected 0/0/0", $signed(pos[0]), rpm[0], dir[0]);
    end
    while (cyc < G + 1) tick();
    checks++;
    if (valid_seen[0] !== 0) begin
      errors++;
      $display("FAIL midreset_discard: %0d pulses before cycle %0d, expected 0", valid_seen[0], G + 2);
    end
    hold(3);
    checks++;
    if (valid_seen[0] !== 1 || rpm[0] !== 11'd0) begin
      errors++;
      $display("FAIL midreset_first: valids %0d rpm %0d expected 1/0", valid_seen[0], rpm[0]);
    end
  endtask

  initial begin
    enc[0] = 2'b00;
    enc[1] = 2'b00;
    test_reset();
    test_quadrature(1'b1);
    test_quadrature(1'b0);
    test_error();
    test_glitch();
    test_random();
    test_fast();
    test_terminal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete within 3 ms");
    $fatal(1);
  end
endmodule
